// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch, decode addi/lw/bne, drive datapath controls.
// Traps on illegal opcodes and on memory-handshake timeouts.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  imem_req,
  input  logic                  imem_valid,
  output logic                  dmem_req,
  input  logic                  dmem_valid,
  input  logic                  EQ,
  output logic                  IRWrite,
  output logic                  ImmSrc,
  output logic                  ALUsrc,
  output logic [2:0]            ALUctrl,
  output logic                  ResultSrc,
  output logic                  RegWrite,
  output logic                  PCen,
  output logic                  PCsrc,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] instret
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_wait;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_instret;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_addi;
  logic       w_lw;
  logic       w_bne;
  logic       w_tmo;
  logic       w_unused_ir;

  assign w_op   = r_ir[6:0];
  assign w_f3   = r_ir[14:12];
  assign w_addi = (w_op == 7'b0010011) && (w_f3 == 3'b000);
  assign w_lw   = (w_op == 7'b0000011) && (w_f3 == 3'b010);
  assign w_bne  = (w_op == 7'b1100011) && (w_f3 == 3'b001);
  assign w_tmo  = (r_wait == CW'(TIMEOUT - 1));

  // Operand/register fields are consumed by the datapath, not here.
  assign w_unused_ir = ^{r_ir[DATA_WIDTH-1:15], r_ir[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_ir      <= '0;
      r_instret <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else if (w_tmo) begin
            r_state <= S_TRAP;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        S_DECODE: begin
          r_wait <= '0;
          unique case (1'b1)
            w_addi:  r_state <= S_EXEC;
            w_lw:    r_state <= S_MEM;
            w_bne:   r_state <= S_BRANCH;
            default: r_state <= S_TRAP;
          endcase
        end
        S_EXEC: begin
          r_state <= S_WB;
          r_wait  <= '0;
        end
        S_MEM: begin
          if (dmem_valid) begin
            r_state <= S_WB;
            r_wait  <= '0;
          end else if (w_tmo) begin
            r_state <= S_TRAP;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        S_WB, S_BRANCH: begin
          r_instret <= r_instret + DATA_WIDTH'(1);
          r_state   <= S_FETCH;
          r_wait    <= '0;
        end
        S_TRAP: begin
          r_state <= S_TRAP;
          r_wait  <= '0;
        end
        default: begin
          r_state <= S_TRAP;
          r_wait  <= '0;
        end
      endcase
    end
  end

  // Controls decode from state and IR; reset masks every output.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    IRWrite   = 1'b0;
    ImmSrc    = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = 3'b000;
    ResultSrc = 1'b0;
    RegWrite  = 1'b0;
    PCen      = 1'b0;
    PCsrc     = 1'b0;
    illegal   = 1'b0;
    instret   = '0;
    if (!rst) begin
      instret = r_instret;
      unique case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_valid;
        end
        S_DECODE: begin
          ImmSrc = w_addi | w_lw;
        end
        S_EXEC: begin
          ImmSrc  = 1'b1;
          ALUsrc  = 1'b1;
          ALUctrl = 3'b000;
        end
        S_MEM: begin
          dmem_req = 1'b1;
          ImmSrc   = 1'b1;
          ALUsrc   = 1'b1;
          ALUctrl  = 3'b000;
        end
        S_WB: begin
          RegWrite  = 1'b1;
          ResultSrc = w_lw;
          PCen      = 1'b1;
          PCsrc     = 1'b0;
        end
        S_BRANCH: begin
          ImmSrc  = 1'b0;
          ALUsrc  = 1'b0;
          ALUctrl = 3'b001;
          PCen    = 1'b1;
          PCsrc   = ~EQ;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule
